sprite_motion_ctrl: RTL and testbench

Parametrised sprite position controller, successor of the fixed 320x240 single-step mover. Converts held direction keys into registered sprite coordinates with a programmable movement rate, diagonal motion, key-conflict cancellation and wrap or clamp edge handling. Speed ramps up while a key is held. Sits between the keyboard decoder and the sprite renderer / VGA pixel generator.

---
 rtl/sprite_motion_ctrl.sv | 134 +++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: held direction keys move a registered sprite
// coordinate at a ramping speed, with wrap or clamp handling at playfield edges.
module sprite_motion_ctrl #(
   parameter int W           = 10,
   parameter int H_RES       = 320,
   parameter int V_RES       = 240,
   parameter int SPR_W       = 16,
   parameter int SPR_H       = 16,
   parameter int INIT_H      = 0,
   parameter int INIT_V      = 0,
   parameter int TICK_DIV    = 4,
   parameter int ACCEL_TICKS = 8,
   parameter int MAX_STEP    = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              A_signal,
   input  logic                              D_signal,
   input  logic                              W_signal,
   input  logic                              S_signal,
   input  logic                              wrap_en,
   output logic [W-1:0]                      pos_h,
   output logic [W-1:0]                      pos_v,
   output logic [$clog2(MAX_STEP+1)-1:0]     step,
   output logic                              moving,
   output logic                              edge_h,
   output logic                              edge_v
);
   // state    | meaning
   // S_IDLE   | no effective direction, step = 1
   // S_ACCEL  | direction held, step ramps every ACCEL_TICKS moves
   // S_CRUISE | direction held, step = MAX_STEP
   typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE} state_t;

   localparam int SW    = $clog2(MAX_STEP + 1);
   localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW    = $clog2(ACCEL_TICKS + 1);
   localparam int MAX_H = H_RES - SPR_W;
   localparam int MAX_V = V_RES - SPR_H;

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic [AW-1:0] accel_cnt;
   logic          tick;
   logic          h_inc, h_dec, v_inc, v_dec, any_dir;
   logic [W:0]    h_nxt, v_nxt;

   // Returns {edge_hit, new_pos}; arithmetic is one bit wider than the coordinate.
   function automatic logic [W:0] axis_next(input logic [W-1:0] pos, input logic inc,
                                            input logic dec, input logic [SW-1:0] stp,
                                            input logic wrap, input int max);
      logic [W:0] p, s, mx, r;
      logic       hit;
      p   = {1'b0, pos};
      s   = (W+1)'(stp);
      mx  = (W+1)'(max);
      r   = p;
      hit = 1'b0;
      if (inc) begin
         r = p + s;
         if (r > mx) begin
            hit = 1'b1;
            r   = wrap ? (r - mx - (W+1)'(1)) : mx;
         end
      end else if (dec) begin
         if (p < s) begin
            hit = 1'b1;
            r   = wrap ? (p + mx + (W+1)'(1) - s) : '0;
         end else begin
            r = p - s;
         end
      end
      return {hit, r[W-1:0]};
   endfunction

   always_comb begin
      tick    = (tick_cnt == TW'(TICK_DIV - 1));
      h_inc   = A_signal & ~D_signal;
      h_dec   = D_signal & ~A_signal;
      v_inc   = W_signal & ~S_signal;
      v_dec   = S_signal & ~W_signal;
      any_dir = h_inc | h_dec | v_inc | v_dec;
      h_nxt   = axis_next(pos_h, h_inc, h_dec, step, wrap_en, MAX_H);
      v_nxt   = axis_next(pos_v, v_inc, v_dec, step, wrap_en, MAX_V);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pos_h     <= W'(INIT_H);
         pos_v     <= W'(INIT_V);
         step      <= SW'(1);
         moving    <= 1'b0;
         edge_h    <= 1'b0;
         edge_v    <= 1'b0;
         tick_cnt  <= '0;
         accel_cnt <= '0;
         state     <= S_IDLE;
      end else begin
         moving   <= 1'b0;
         edge_h   <= 1'b0;
         edge_v   <= 1'b0;
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         if (tick) begin
            pos_h  <= h_nxt[W-1:0];
            pos_v  <= v_nxt[W-1:0];
            edge_h <= h_nxt[W];
            edge_v <= v_nxt[W];
            moving <= (h_nxt[W-1:0] != pos_h) || (v_nxt[W-1:0] != pos_v);
         end
         // Releasing every key (or full cancellation) drops speed even between ticks.
         if (!any_dir) begin
            state     <= S_IDLE;
            step      <= SW'(1);
            accel_cnt <= '0;
         end else if (tick) begin
            case (state)
               S_IDLE, S_ACCEL: begin
                  if (step == SW'(MAX_STEP)) begin
                     state <= S_CRUISE;
                  end else if (accel_cnt == AW'(ACCEL_TICKS - 1)) begin
                     accel_cnt <= '0;
                     step      <= step + SW'(1);
                     state     <= ((step + SW'(1)) == SW'(MAX_STEP)) ? S_CRUISE : S_ACCEL;
                  end else begin
                     accel_cnt <= accel_cnt + AW'(1);
                     state     <= S_ACCEL;
                  end
               end
               default: state <= S_CRUISE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: several parameterisations share one clock,
// expected values flow through a scoreboard queue and are checked with assertions.
module tb_sprite_motion_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   // default instance
   logic rst_def, def_a, def_d, def_w, def_s, def_wrap;
   logic [9:0] def_ph, def_pv;
   logic [2:0] def_step;
   logic def_mov, def_eh, def_ev;
   // accel instance
   logic rst_acc, acc_a, acc_d, acc_w, acc_s, acc_wrap;
   logic [9:0] acc_ph, acc_pv;
   logic [1:0] acc_step;
   logic acc_mov, acc_eh, acc_ev;
   // clamp instance
   logic rst_oth, clp_a, clp_d, clp_w, clp_s, clp_wrap;
   logic [9:0] clp_ph, clp_pv;
   logic [0:0] clp_step;
   logic clp_mov, clp_eh, clp_ev;
   // wrap instance
   logic wrp_a, wrp_d, wrp_w, wrp_s, wrp_wrap;
   logic [9:0] wrp_ph, wrp_pv;
   logic [0:0] wrp_step;
   logic wrp_mov, wrp_eh, wrp_ev;
   // conflict instance
   logic cnf_a, cnf_d, cnf_w, cnf_s, cnf_wrap;
   logic [9:0] cnf_ph, cnf_pv;
   logic [0:0] cnf_step;
   logic cnf_mov, cnf_eh, cnf_ev;

   sprite_motion_ctrl u_def (
      .clk(clk), .rst(rst_def), .A_signal(def_a), .D_signal(def_d), .W_signal(def_w),
      .S_signal(def_s), .wrap_en(def_wrap), .pos_h(def_ph), .pos_v(def_pv), .step(def_step),
      .moving(def_mov), .edge_h(def_eh), .edge_v(def_ev));

   sprite_motion_ctrl #(.TICK_DIV(2), .ACCEL_TICKS(2), .MAX_STEP(3)) u_acc (
      .clk(clk), .rst(rst_acc), .A_signal(acc_a), .D_signal(acc_d), .W_signal(acc_w),
      .S_signal(acc_s), .wrap_en(acc_wrap), .pos_h(acc_ph), .pos_v(acc_pv), .step(acc_step),
      .moving(acc_mov), .edge_h(acc_eh), .edge_v(acc_ev));

   sprite_motion_ctrl #(.TICK_DIV(1), .MAX_STEP(1)) u_clp (
      .clk(clk), .rst(rst_oth), .A_signal(clp_a), .D_signal(clp_d), .W_signal(clp_w),
      .S_signal(clp_s), .wrap_en(clp_wrap), .pos_h(clp_ph), .pos_v(clp_pv), .step(clp_step),
      .moving(clp_mov), .edge_h(clp_eh), .edge_v(clp_ev));

   sprite_motion_ctrl #(.TICK_DIV(1), .MAX_STEP(1), .INIT_H(304), .INIT_V(0)) u_wrp (
      .clk(clk), .rst(rst_oth), .A_signal(wrp_a), .D_signal(wrp_d), .W_signal(wrp_w),
      .S_signal(wrp_s), .wrap_en(wrp_wrap), .pos_h(wrp_ph), .pos_v(wrp_pv), .step(wrp_step),
      .moving(wrp_mov), .edge_h(wrp_eh), .edge_v(wrp_ev));

   sprite_motion_ctrl #(.TICK_DIV(1), .MAX_STEP(1), .INIT_H(10), .INIT_V(10)) u_cnf (
      .clk(clk), .rst(rst_oth), .A_signal(cnf_a), .D_signal(cnf_d), .W_signal(cnf_w),
      .S_signal(cnf_s), .wrap_en(cnf_wrap), .pos_h(cnf_ph), .pos_v(cnf_pv), .step(cnf_step),
      .moving(cnf_mov), .edge_h(cnf_eh), .edge_v(cnf_ev));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] exp);
      sb.push_back(exp);
   endtask

   task automatic check_pop(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed %0d expected <scoreboard empty>", tag, obs);
      end else begin
         e = sb.pop_front();
         check(tag, obs, e);
      end
   endtask

   initial begin
      logic [31:0] rst_vec;
      int acc_exp[7];
      acc_exp = '{1, 2, 4, 6, 9, 12, 15};
      rst_vec = {6'd0, 10'd0, 10'd0, 3'd1, 3'd0};

      {rst_def, rst_acc, rst_oth} = 3'b000;
      {def_a, def_d, def_w, def_s, def_wrap} = '0;
      {acc_a, acc_d, acc_w, acc_s, acc_wrap} = '0;
      {clp_a, clp_d, clp_w, clp_s, clp_wrap} = '0;
      {wrp_a, wrp_d, wrp_w, wrp_s, wrp_wrap} = '0;
      {cnf_a, cnf_d, cnf_w, cnf_s, cnf_wrap} = '0;

      // Reset held with a key pressed
      def_a = 1'b1;
      push(rst_vec);
      repeat (3) cyc();
      check_pop("reset_def", {6'd0, def_ph, def_pv, def_step, def_mov, def_eh, def_ev});
      check("reset_acc_step", acc_step, 1);
      check("reset_clp_h", clp_ph, 0);
      check("reset_wrp_h", wrp_ph, 304);
      check("reset_cnf_h", cnf_ph, 10);
      check("reset_cnf_v", cnf_pv, 10);

      // Release reset with no keys: outputs stay put
      def_a   = 1'b0;
      rst_def = 1'b1;
      rst_oth = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push(rst_vec);
         cyc();
         check_pop("idle_def", {6'd0, def_ph, def_pv, def_step, def_mov, def_eh, def_ev});
      end

      // Acceleration ramp
      rst_acc = 1'b1;
      acc_a   = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc();
         check("acc_nontick_mov", acc_mov, 0);
         push(acc_exp[i]);
         cyc();
         check_pop("acc_pos_h", acc_ph);
         check("acc_tick_mov", acc_mov, 1);
         if (i == 1) check("acc_step2", acc_step, 2);
      end
      check("acc_step_final", acc_step, 3);

      // One-cycle release drops speed back to 1
      acc_a = 1'b0;
      cyc();
      check("acc_release_step", acc_step, 1);
      acc_a = 1'b1;
      cyc();
      check("acc_restart_pos", acc_ph, 16);
      check("acc_restart_step", acc_step, 1);
      repeat (6) cyc();
      check("acc_ramp2_pos", acc_ph, 21);
      check("acc_ramp2_step", acc_step, 3);

      // Reset mid-motion
      rst_acc = 1'b0;
      cyc();
      check("acc_midrst_pos", acc_ph, 0);
      check("acc_midrst_step", acc_step, 1);
      check("acc_midrst_mov", acc_mov, 0);
      rst_acc = 1'b1;
      cyc();
      check("acc_post_rst_hold", acc_ph, 0);
      cyc();
      check("acc_post_rst_tick", acc_ph, 1);
      acc_a = 1'b0;

      // Clamp at the low edge
      clp_d = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(0);
         cyc();
         check_pop("clp_low_pos", clp_ph);
         check("clp_low_edge", clp_eh, 1);
         check("clp_low_mov", clp_mov, 0);
      end
      clp_d = 1'b0;
      clp_a = 1'b1;
      for (int i = 1; i <= 400; i++) begin
         push((i > 304) ? 304 : i);
         cyc();
         check_pop("clp_high_pos", clp_ph);
         check("clp_high_edge", clp_eh, (i >= 305) ? 1 : 0);
      end
      check("clp_high_mov", clp_mov, 0);
      clp_a = 1'b0;

      // Wrap on both axes
      wrp_wrap = 1'b1;
      wrp_a    = 1'b1;
      cyc();
      check("wrp_h_pos", wrp_ph, 0);
      check("wrp_h_edge", wrp_eh, 1);
      check("wrp_h_mov", wrp_mov, 1);
      check("wrp_h_edgev", wrp_ev, 0);
      wrp_a = 1'b0;
      wrp_s = 1'b1;
      cyc();
      check("wrp_v_pos", wrp_pv, 224);
      check("wrp_v_edge", wrp_ev, 1);
      check("wrp_v_posh", wrp_ph, 0);
      check("wrp_v_edgeh", wrp_eh, 0);
      wrp_s = 1'b0;
      cyc();
      check("wrp_quiet_edge", wrp_ev, 0);
      check("wrp_quiet_mov", wrp_mov, 0);

      // Horizontal conflict with vertical motion
      {cnf_a, cnf_d, cnf_w} = 3'b111;
      for (int i = 1; i <= 5; i++) begin
         push(10 + i);
         cyc();
         check_pop("cnf_pos_v", cnf_pv);
         check("cnf_pos_h", cnf_ph, 10);
         check("cnf_mov", cnf_mov, 1);
      end
      cnf_s = 1'b1;
      repeat (2) begin
         cyc();
         check("cnf_all_h", cnf_ph, 10);
         check("cnf_all_v", cnf_pv, 15);
         check("cnf_all_mov", cnf_mov, 0);
         check("cnf_all_step", cnf_step, 1);
      end

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
